// File: rtl/axis_pkg.sv
// Shared helpers for the axis_* stream blocks: ceil-log2 and select-index width.
package axis_pkg;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of an index that names one of n streams; never narrower than 1 bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: picks the first requester after
// last_ptr, wrapping modulo NUM_INPUTS. Returns one-hot and encoded grant.
module rr_select #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  last_ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [SEL_WIDTH-1:0]  grant_idx,
  output logic                  grant_any
);

  // Scan last_ptr+1, last_ptr+2, ... and keep the first requester found.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = (int'(last_ptr) + k) % NUM_INPUTS;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-stream arbiter with a registered output stage.
// Optional packet locking is enabled by defining AXIS_RR_ARBITER_PACKET_LOCK_EN.
//
// Handshake: a beat moves on a port in the cycle where tvalid && tready are
// both high at the rising clock edge. s_tready is combinational from s_tvalid,
// m_tready and local state; a source must hold tvalid and its data until taken.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = sel_width(NUM_INPUTS)
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_INPUTS-1:0]            s_tlast,
  input  logic [NUM_INPUTS-1:0]            s_tvalid,
  output logic [NUM_INPUTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [SEL_WIDTH-1:0]             m_tuser,
  output logic                             m_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready
);

  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [SEL_WIDTH-1:0]  m_tuser_q, m_tuser_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [SEL_WIDTH-1:0]  last_ptr_q, last_ptr_d;

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  grant_any;
  logic                  load_en;

`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
  logic                  lock_q, lock_d;
  logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;

  // While a packet is open only its owner may request; everyone else waits.
  always_comb begin
    req = s_tvalid;
    if (lock_q) begin
      req = '0;
      req[lock_idx_q] = s_tvalid[lock_idx_q];
    end
  end
`else
  assign req = s_tvalid;
`endif

  rr_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_rr_select (
    .req       (req),
    .last_ptr  (last_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Output register can take a new beat when empty or being drained this cycle.
  assign load_en  = !m_tvalid_q || m_tready;
  assign s_tready = (resetn && load_en) ? grant : '0;

  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;

  // Next-state: load the granted beat, or empty the register when nobody asks.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    last_ptr_d = last_ptr_q;
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (load_en) begin
      if (grant_any) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        m_tlast_d  = s_tlast[grant_idx];
        m_tuser_d  = grant_idx;
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
        // Rotation advances only at packet boundaries.
        if (s_tlast[grant_idx]) begin
          lock_d     = 1'b0;
          last_ptr_d = grant_idx;
        end else begin
          lock_d     = 1'b1;
          lock_idx_d = grant_idx;
        end
`else
        last_ptr_d = grant_idx;
`endif
      end else begin
        m_tvalid_d = 1'b0;
      end
    end
  end

  // State register; reset leaves input 0 first in line and drops any held beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      last_ptr_q <= SEL_WIDTH'(NUM_INPUTS - 1);
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
      last_ptr_q <= last_ptr_d;
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

endmodule
